// File: rtl/proc_pkg.sv
// Shared types for the packet sequencer: FSM states, stage index and
// the enabled-stage search used to walk the match/execute pipeline.
package proc_pkg;

  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;
  localparam int   MAX_STAGES = 8;

  typedef enum logic [2:0] {
    FREE,
    PS_WAIT,
    MT_WAIT,
    EX_WAIT,
    OUT_WAIT,
    LATCH,
    DROP
  } state_e;

  typedef logic [2:0] stage_idx_t;

  typedef struct packed {
    logic       found;
    stage_idx_t idx;
  } stage_sel_t;

  // Lowest enabled stage whose index is >= from; from = MAX_STAGES means none.
  function automatic stage_sel_t find_stage(input logic [MAX_STAGES-1:0] mask,
                                            input logic [3:0]            from);
    stage_sel_t r;
    r.found = FALSE;
    r.idx   = '0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = TRUE;
        r.idx   = stage_idx_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/proc_watchdog.sv
// Wait-state watchdog: loads 1 on a unit start, counts each enabled cycle,
// and flags expiry in the cycle the count reaches TIMEOUT_CYCLES.
module proc_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = TO_W'(1);
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign expire_o = enable_i && (count_d == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/proc_seq.sv
// Packet sequencer: walks one packet through the parser and the enabled
// match/execute stage pairs, with bypass, drops, watchdog and TM pass-through.
module proc_seq
  import proc_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_empty_i,
  output logic                  in_rd_o,
  input  logic                  out_empty_i,
  output logic                  out_wr_o,
  input  logic                  tm_valid_i,
  output logic                  sel_tm_o,
  input  logic [NUM_STAGES-1:0] stage_en_i,
  output logic                  ps_start_o,
  input  logic                  ps_ready_i,
  output logic [NUM_STAGES-1:0] mt_start_o,
  input  logic [NUM_STAGES-1:0] mt_ready_i,
  output logic [NUM_STAGES-1:0] ex_start_o,
  input  logic [NUM_STAGES-1:0] ex_ready_i,
  input  logic [NUM_STAGES-1:0] ex_drop_i,
  output logic [2:0]            cur_stage_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      pkt_out_cnt_o,
  output logic [CNT_W-1:0]      pkt_drop_cnt_o,
  output logic [CNT_W-1:0]      timeout_cnt_o
);

  state_e                  state_q;
  stage_idx_t              stage_q;
  logic [NUM_STAGES-1:0]   en_q;
  logic [NUM_STAGES-1:0]   mt_start_q;
  logic [NUM_STAGES-1:0]   ex_start_q;
  logic                    ps_start_q;
  logic                    in_rd_q;
  logic                    out_wr_q;
  logic                    sel_tm_q;
  logic [CNT_W-1:0]        out_cnt_q;
  logic [CNT_W-1:0]        drop_cnt_q;
  logic [CNT_W-1:0]        to_cnt_q;

  logic [NUM_STAGES-1:0]   stage_oh;
  logic                    mt_rdy;
  logic                    ex_rdy;
  logic                    ex_drp;
  logic                    wd_clear;
  logic                    wd_enable;
  logic                    wd_expire;
  stage_sel_t              first_sel;
  stage_sel_t              next_sel;

  function automatic logic [NUM_STAGES-1:0] stage_bit(input stage_idx_t idx);
    logic [NUM_STAGES-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_idx_t'(i) == idx) b[i] = TRUE;
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_oh
    assign stage_oh[gi] = (stage_q == stage_idx_t'(gi));
  end

  assign mt_rdy    = |(mt_ready_i & stage_oh);
  assign ex_rdy    = |(ex_ready_i & stage_oh);
  assign ex_drp    = |(ex_drop_i & stage_oh);
  assign first_sel = find_stage(MAX_STAGES'(en_q), 4'd0);
  assign next_sel  = find_stage(MAX_STAGES'(en_q), {1'b0, stage_q} + 4'd1);

  // A start pulse marks the first WAIT cycle: it reloads the watchdog and masks ready.
  assign wd_clear  = ps_start_q | (|mt_start_q) | (|ex_start_q);
  assign wd_enable = (state_q == PS_WAIT) || (state_q == MT_WAIT) || (state_q == EX_WAIT);

  proc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear_i (wd_clear),
    .enable_i(wd_enable),
    .expire_o(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      stage_q    <= '0;
      en_q       <= '0;
      mt_start_q <= '0;
      ex_start_q <= '0;
      ps_start_q <= FALSE;
      in_rd_q    <= FALSE;
      out_wr_q   <= FALSE;
      sel_tm_q   <= FALSE;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      ps_start_q <= FALSE;
      mt_start_q <= '0;
      ex_start_q <= '0;
      in_rd_q    <= FALSE;
      out_wr_q   <= FALSE;
      unique case (state_q)
        FREE: begin
          if (!in_empty_i) begin
            if (tm_valid_i) begin
              if (out_empty_i) begin
                sel_tm_q <= TRUE;
                in_rd_q  <= TRUE;
                out_wr_q <= TRUE;
                state_q  <= LATCH;
              end
            end else begin
              en_q       <= stage_en_i;
              sel_tm_q   <= FALSE;
              ps_start_q <= TRUE;
              stage_q    <= '0;
              state_q    <= PS_WAIT;
            end
          end
        end
        PS_WAIT: begin
          if (!ps_start_q && ps_ready_i) begin
            if (first_sel.found) begin
              stage_q    <= first_sel.idx;
              mt_start_q <= stage_bit(first_sel.idx);
              state_q    <= MT_WAIT;
            end else if (out_empty_i) begin
              in_rd_q  <= TRUE;
              out_wr_q <= TRUE;
              state_q  <= LATCH;
            end else begin
              state_q <= OUT_WAIT;
            end
          end else if (wd_expire) begin
            in_rd_q  <= TRUE;
            to_cnt_q <= sat_inc(to_cnt_q);
            state_q  <= DROP;
          end
        end
        MT_WAIT: begin
          if (!(|mt_start_q) && mt_rdy) begin
            ex_start_q <= stage_bit(stage_q);
            state_q    <= EX_WAIT;
          end else if (wd_expire) begin
            in_rd_q  <= TRUE;
            to_cnt_q <= sat_inc(to_cnt_q);
            state_q  <= DROP;
          end
        end
        EX_WAIT: begin
          if (!(|ex_start_q) && ex_rdy) begin
            if (ex_drp) begin
              in_rd_q    <= TRUE;
              drop_cnt_q <= sat_inc(drop_cnt_q);
              state_q    <= DROP;
            end else if (next_sel.found) begin
              stage_q    <= next_sel.idx;
              mt_start_q <= stage_bit(next_sel.idx);
              state_q    <= MT_WAIT;
            end else if (out_empty_i) begin
              in_rd_q  <= TRUE;
              out_wr_q <= TRUE;
              state_q  <= LATCH;
            end else begin
              state_q <= OUT_WAIT;
            end
          end else if (wd_expire) begin
            in_rd_q  <= TRUE;
            to_cnt_q <= sat_inc(to_cnt_q);
            state_q  <= DROP;
          end
        end
        OUT_WAIT: begin
          if (out_empty_i) begin
            in_rd_q  <= TRUE;
            out_wr_q <= TRUE;
            state_q  <= LATCH;
          end
        end
        LATCH: begin
          out_cnt_q <= sat_inc(out_cnt_q);
          state_q   <= FREE;
        end
        DROP: begin
          state_q <= FREE;
        end
        default: begin
          state_q <= FREE;
        end
      endcase
    end
  end

  assign in_rd_o        = in_rd_q;
  assign out_wr_o       = out_wr_q;
  assign sel_tm_o       = sel_tm_q;
  assign ps_start_o     = ps_start_q;
  assign mt_start_o     = mt_start_q;
  assign ex_start_o     = ex_start_q;
  assign cur_stage_o    = stage_q;
  assign busy_o         = (state_q != FREE);
  assign pkt_out_cnt_o  = out_cnt_q;
  assign pkt_drop_cnt_o = drop_cnt_q;
  assign timeout_cnt_o  = to_cnt_q;

endmodule

// File: tb/tb_proc_seq.sv
// Directed bench for proc_seq: a unit responder answers every start one cycle
// later, and a scoreboard of expected pulse events (vector, cycle) is checked.
module tb_proc_seq;

  localparam int NS = 2;

  localparam logic [6:0] E_LATCH = 7'b1100000;
  localparam logic [6:0] E_DROP  = 7'b1000000;
  localparam logic [6:0] E_PS    = 7'b0010000;
  localparam logic [6:0] E_MT0   = 7'b0000100;
  localparam logic [6:0] E_MT1   = 7'b0001000;
  localparam logic [6:0] E_EX0   = 7'b0000001;
  localparam logic [6:0] E_EX1   = 7'b0000010;

  logic          clk;
  logic          rst;
  logic          in_empty_i;
  logic          in_rd_o;
  logic          out_empty_i;
  logic          out_wr_o;
  logic          tm_valid_i;
  logic          sel_tm_o;
  logic [NS-1:0] stage_en_i;
  logic          ps_start_o;
  logic          ps_ready_i;
  logic [NS-1:0] mt_start_o;
  logic [NS-1:0] mt_ready_i;
  logic [NS-1:0] ex_start_o;
  logic [NS-1:0] ex_ready_i;
  logic [NS-1:0] ex_drop_i;
  logic [2:0]    cur_stage_o;
  logic          busy_o;
  logic [31:0]   pkt_out_cnt_o;
  logic [31:0]   pkt_drop_cnt_o;
  logic [31:0]   timeout_cnt_o;

  proc_seq #(
    .NUM_STAGES    (NS),
    .TIMEOUT_CYCLES(8),
    .TO_W          (4),
    .CNT_W         (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_empty_i    (in_empty_i),
    .in_rd_o       (in_rd_o),
    .out_empty_i   (out_empty_i),
    .out_wr_o      (out_wr_o),
    .tm_valid_i    (tm_valid_i),
    .sel_tm_o      (sel_tm_o),
    .stage_en_i    (stage_en_i),
    .ps_start_o    (ps_start_o),
    .ps_ready_i    (ps_ready_i),
    .mt_start_o    (mt_start_o),
    .mt_ready_i    (mt_ready_i),
    .ex_start_o    (ex_start_o),
    .ex_ready_i    (ex_ready_i),
    .ex_drop_i     (ex_drop_i),
    .cur_stage_o   (cur_stage_o),
    .busy_o        (busy_o),
    .pkt_out_cnt_o (pkt_out_cnt_o),
    .pkt_drop_cnt_o(pkt_drop_cnt_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  typedef struct {
    logic [6:0] ev;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [1:0]  drop_mask = 2'b00;
  logic [1:0]  mt_block = 2'b00;
  logic        last_sel;
  logic [2:0]  last_stage;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] ev, input int c);
    exp_t e;
    e.ev  = ev;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Unit responder and scoreboard monitor, both 1 time unit after each rising edge.
  initial begin
    logic       ps_last;
    logic [1:0] mt_last;
    logic [1:0] ex_last;
    logic [6:0] obs;
    exp_t       e;
    ps_last = 1'b0;
    mt_last = '0;
    ex_last = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ps_ready_i = ps_last;
      mt_ready_i = mt_last & ~mt_block;
      ex_ready_i = ex_last;
      ex_drop_i  = ex_last & drop_mask;
      ps_last    = ps_start_o;
      mt_last    = mt_start_o;
      ex_last    = ex_start_o;
      obs = {in_rd_o, out_wr_o, ps_start_o, mt_start_o, ex_start_o};
      if (obs != 7'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {25'b0, obs}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("pulse_event", {9'b0, obs, 16'(cyc - t0)}, {9'b0, e.ev, 16'(e.cyc)});
        end
      end
    end
  end

  // Called on a falling edge; the accept cycle is the current one (relative cycle 0).
  task automatic send(input logic [1:0] en, input logic [1:0] dmask, input logic [1:0] mblock,
                      input logic tm, input int hold);
    logic done;
    done        = 1'b0;
    stage_en_i  = en;
    drop_mask   = dmask;
    mt_block    = mblock;
    tm_valid_i  = tm;
    out_empty_i = (hold == 0);
    in_empty_i  = 1'b0;
    t0          = cyc;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (hold > 0 && (cyc - t0) == hold) out_empty_i = 1'b1;
      if (in_rd_o) begin
        done       = 1'b1;
        last_sel   = sel_tm_o;
        last_stage = cur_stage_o;
      end
    end
    chk("pkt_done", {31'b0, done}, 32'h1);
    in_empty_i = 1'b1;
    tm_valid_i = 1'b0;
    @(negedge clk);
    chk("queue_drained", sb.size(), 32'h0);
  endtask

  task automatic chk_cnt(input string tag, input int o, input int d, input int t);
    chk({tag, "_out_cnt"}, pkt_out_cnt_o, o);
    chk({tag, "_drop_cnt"}, pkt_drop_cnt_o, d);
    chk({tag, "_to_cnt"}, timeout_cnt_o, t);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
  endtask

  task automatic push_full();
    push(E_PS, 1);
    push(E_MT0, 3);
    push(E_EX0, 5);
    push(E_MT1, 7);
    push(E_EX1, 9);
    push(E_LATCH, 11);
  endtask

  initial begin
    rst         = 1'b1;
    in_empty_i  = 1'b1;
    out_empty_i = 1'b1;
    tm_valid_i  = 1'b0;
    stage_en_i  = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {20'b0, in_rd_o, out_wr_o, sel_tm_o, ps_start_o, mt_start_o,
                          ex_start_o, cur_stage_o, busy_o}, 32'h0);
    chk_cnt("reset", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    push_full();
    send(2'b11, 2'b00, 2'b00, 1'b0, 0);
    chk_cnt("full", 1, 0, 0);
    chk("full_last_stage", {29'b0, last_stage}, 32'h1);

    push(E_PS, 1);
    push(E_MT1, 3);
    push(E_EX1, 5);
    push(E_LATCH, 7);
    send(2'b10, 2'b00, 2'b00, 1'b0, 0);
    chk_cnt("bypass0", 2, 0, 0);

    push(E_PS, 1);
    push(E_MT0, 3);
    push(E_EX0, 5);
    push(E_DROP, 7);
    send(2'b11, 2'b01, 2'b00, 1'b0, 0);
    chk_cnt("exdrop", 2, 1, 0);
    chk("exdrop_stage", {29'b0, last_stage}, 32'h0);

    push(E_PS, 1);
    push(E_MT0, 3);
    push(E_DROP, 11);
    send(2'b11, 2'b00, 2'b01, 1'b0, 0);
    chk_cnt("timeout", 2, 1, 1);

    push_full();
    send(2'b11, 2'b00, 2'b00, 1'b0, 0);
    chk_cnt("after_timeout", 3, 1, 1);

    push(E_LATCH, 6);
    send(2'b11, 2'b00, 2'b00, 1'b1, 5);
    chk_cnt("tm", 4, 1, 1);
    chk("tm_sel", {31'b0, last_sel}, 32'h1);

    push_full();
    send(2'b11, 2'b00, 2'b00, 1'b0, 0);
    chk_cnt("after_tm", 5, 1, 1);
    chk("after_tm_sel", {31'b0, last_sel}, 32'h0);

    // Output latch busy well past the watchdog limit: must wait, not time out.
    push(E_PS, 1);
    push(E_MT0, 3);
    push(E_EX0, 5);
    push(E_MT1, 7);
    push(E_EX1, 9);
    push(E_LATCH, 26);
    send(2'b11, 2'b00, 2'b00, 1'b0, 25);
    chk_cnt("out_wait", 6, 1, 1);

    push(E_PS, 1);
    push(E_MT0, 3);
    push(E_EX0, 5);
    stage_en_i  = 2'b11;
    drop_mask   = 2'b00;
    mt_block    = 2'b00;
    out_empty_i = 1'b1;
    in_empty_i  = 1'b0;
    t0          = cyc;
    for (int i = 0; i < 20 && (cyc - t0) < 5; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {20'b0, in_rd_o, out_wr_o, sel_tm_o, ps_start_o, mt_start_o,
                           ex_start_o, cur_stage_o, busy_o}, 32'h0);
    chk_cnt("midrst", 0, 0, 0);
    rst        = 1'b0;
    in_empty_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_queue", sb.size(), 32'h0);

    push_full();
    send(2'b11, 2'b00, 2'b00, 1'b0, 0);
    chk_cnt("after_rst", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
